// File: rtl/rv32i_types.sv
// Shared RV32I types: data-memory responder state encoding, line geometry and byte-merge helpers.
package rv32i_types;

   typedef enum logic [2:0] {IDLE, RESP, WB, FILL_REQ, FILL} dmem_state_t;

   localparam int LINE_BYTES  = 32;
   localparam int BMEM_BEAT_W = 64;
   localparam int OFFSET_W    = 5;
   localparam int TAG_W       = 32 - OFFSET_W;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = mask[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
      end
      return res;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/dmem_line_store.sv
// Single 256-bit write-back line: data array, tag, valid and dirty, with byte-masked word and beat write ports.
module dmem_line_store
   import rv32i_types::*;
#(
   parameter int LINE_BEATS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   word_we,
   input  logic [2:0]             word_idx,
   input  logic [3:0]             word_wmask,
   input  logic [31:0]            word_wdata,
   input  logic                   beat_we,
   input  logic [1:0]             beat_widx,
   input  logic [BMEM_BEAT_W-1:0] beat_wdata,
   input  logic [1:0]             beat_ridx,
   input  logic                   fill_done,
   input  logic [TAG_W-1:0]       fill_tag,
   input  logic                   clr_dirty,
   output logic [31:0]            word_rdata,
   output logic [BMEM_BEAT_W-1:0] beat_rdata,
   output logic [TAG_W-1:0]       tag,
   output logic                   valid,
   output logic                   dirty
);

   logic [LINE_BEATS-1:0][BMEM_BEAT_W-1:0] data_q, data_d;
   logic [TAG_W-1:0]       tag_q, tag_d;
   logic                   valid_q, valid_d;
   logic                   dirty_q, dirty_d;
   logic [BMEM_BEAT_W-1:0] word_beat;

   assign word_beat  = data_q[word_idx[2:1]];
   assign word_rdata = word_idx[0] ? word_beat[63:32] : word_beat[31:0];
   assign beat_rdata = data_q[beat_ridx];
   assign tag        = tag_q;
   assign valid      = valid_q;
   assign dirty      = dirty_q;

   always_comb begin
      data_d = data_q;
      if (beat_we) data_d[beat_widx] = beat_wdata;
      if (word_we) begin
         if (word_idx[0]) data_d[word_idx[2:1]][63:32] = byte_merge(word_beat[63:32], word_wdata, word_wmask);
         else             data_d[word_idx[2:1]][31:0]  = byte_merge(word_beat[31:0],  word_wdata, word_wmask);
      end
   end

   // Fill completion overrides any dirty update: a fresh line is always clean.
   always_comb begin
      tag_d   = tag_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (word_we)   dirty_d = 1'b1;
      if (clr_dirty) dirty_d = 1'b0;
      if (fill_done) begin
         tag_d   = fill_tag;
         valid_d = 1'b1;
         dirty_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_q   <= '0;
         valid_q <= 1'b0;
         dirty_q <= 1'b0;
      end else begin
         tag_q   <= tag_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one-line write-back buffer in front of 4x64-bit burst memory.
// Optional DMEM_PERF_CNT_EN adds saturating hit_count / miss_count outputs.
module dmem_responder
   import rv32i_types::*;
#(
   parameter int LINE_BEATS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic [31:0] bmem_addr,
   output logic        bmem_read,
   output logic        bmem_write,
   output logic [63:0] bmem_wdata,
   input  logic        bmem_ready,
   input  logic [31:0] bmem_raddr,
   input  logic [63:0] bmem_rdata,
   input  logic        bmem_rvalid
`ifdef DMEM_PERF_CNT_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   dmem_state_t state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        dmem_resp_q, dmem_resp_d;
   logic [31:0] dmem_rdata_q, dmem_rdata_d;
   logic [31:0] bmem_addr_q, bmem_addr_d;
   logic        bmem_read_q, bmem_read_d;
   logic        bmem_write_q, bmem_write_d;
   logic [63:0] bmem_wdata_q, bmem_wdata_d;

   logic             req, is_store, hit;
   logic             word_we, beat_we, fill_done, clr_dirty;
   logic [1:0]       beat_ridx;
   logic [31:0]      word_rdata;
   logic [63:0]      beat_rdata;
   logic [TAG_W-1:0] line_tag;
   logic             line_valid, line_dirty;
   logic             unused_addr_bits;

   assign req              = (|dmem_rmask) | (|dmem_wmask);
   assign is_store         = |dmem_wmask;
   assign hit              = line_valid && (line_tag == dmem_addr[31:OFFSET_W]);
   assign unused_addr_bits = ^dmem_addr[1:0];
   // WB presents the next beat one cycle ahead so the registered bmem_wdata advances on acceptance.
   assign beat_ridx        = (state_q == WB) ? cnt_q + 2'd1 : 2'd0;

   dmem_line_store #(.LINE_BEATS(LINE_BEATS)) u_line (
      .clk        (clk),
      .rst        (rst),
      .word_we    (word_we),
      .word_idx   (dmem_addr[4:2]),
      .word_wmask (dmem_wmask),
      .word_wdata (dmem_wdata),
      .beat_we    (beat_we),
      .beat_widx  (cnt_q),
      .beat_wdata (bmem_rdata),
      .beat_ridx  (beat_ridx),
      .fill_done  (fill_done),
      .fill_tag   (dmem_addr[31:OFFSET_W]),
      .clr_dirty  (clr_dirty),
      .word_rdata (word_rdata),
      .beat_rdata (beat_rdata),
      .tag        (line_tag),
      .valid      (line_valid),
      .dirty      (line_dirty)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dmem_resp_d  = 1'b0;
      dmem_rdata_d = dmem_rdata_q;
      bmem_addr_d  = bmem_addr_q;
      bmem_read_d  = bmem_read_q;
      bmem_write_d = bmem_write_q;
      bmem_wdata_d = bmem_wdata_q;
      word_we      = 1'b0;
      beat_we      = 1'b0;
      fill_done    = 1'b0;
      clr_dirty    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req && hit) begin
               state_d      = RESP;
               dmem_resp_d  = 1'b1;
               word_we      = is_store;
               dmem_rdata_d = is_store ? byte_merge(word_rdata, dmem_wdata, dmem_wmask) : word_rdata;
            end else if (req && line_dirty) begin
               state_d      = WB;
               cnt_d        = 2'd0;
               bmem_write_d = 1'b1;
               bmem_addr_d  = {line_tag, {OFFSET_W{1'b0}}};
               bmem_wdata_d = beat_rdata;
            end else if (req) begin
               state_d     = FILL_REQ;
               bmem_read_d = 1'b1;
               bmem_addr_d = {dmem_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            end
         end
         RESP: state_d = IDLE;
         WB: begin
            if (bmem_ready) begin
               cnt_d        = cnt_q + 2'd1;
               bmem_wdata_d = beat_rdata;
               if (cnt_q == 2'd3) begin
                  state_d      = FILL_REQ;
                  clr_dirty    = 1'b1;
                  bmem_write_d = 1'b0;
                  bmem_read_d  = 1'b1;
                  bmem_addr_d  = {dmem_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
               end
            end
         end
         FILL_REQ: begin
            if (bmem_ready) begin
               state_d     = FILL;
               bmem_read_d = 1'b0;
            end
         end
         FILL: begin
            if (bmem_rvalid) begin
               beat_we = 1'b1;
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  fill_done = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= 2'd0;
         dmem_resp_q  <= 1'b0;
         dmem_rdata_q <= '0;
         bmem_addr_q  <= '0;
         bmem_read_q  <= 1'b0;
         bmem_write_q <= 1'b0;
         bmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dmem_resp_q  <= dmem_resp_d;
         dmem_rdata_q <= dmem_rdata_d;
         bmem_addr_q  <= bmem_addr_d;
         bmem_read_q  <= bmem_read_d;
         bmem_write_q <= bmem_write_d;
         bmem_wdata_q <= bmem_wdata_d;
      end
   end

   assign dmem_resp  = dmem_resp_q;
   assign dmem_rdata = dmem_rdata_q;
   assign bmem_addr  = bmem_addr_q;
   assign bmem_read  = bmem_read_q;
   assign bmem_write = bmem_write_q;
   assign bmem_wdata = bmem_wdata_q;

`ifdef DMEM_PERF_CNT_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;
   logic        refill_q, refill_d;

   // refill marks the IDLE cycle right after a fill, whose retry must not be counted twice.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      refill_d     = refill_q;
      if (fill_done) refill_d = 1'b1;
      if (state_q == IDLE) begin
         refill_d = 1'b0;
         if (req && !refill_q) begin
            if (hit) hit_count_d  = sat_inc(hit_count_q);
            else     miss_count_d = sat_inc(miss_count_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
         refill_q     <= 1'b0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         refill_q     <= refill_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

   a_one_mask: assert property (@(posedge clk) disable iff (!rst)
      !((|dmem_rmask) && (|dmem_wmask)));
   a_fill_addr: assert property (@(posedge clk) disable iff (!rst)
      (state_q == FILL && bmem_rvalid) |-> (bmem_raddr == bmem_addr_q));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a small burst-memory model driving the bmem side.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask, dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic [31:0] bmem_addr;
   logic        bmem_read, bmem_write;
   logic [63:0] bmem_wdata;
   logic        bmem_ready;
   logic [31:0] bmem_raddr;
   logic [63:0] bmem_rdata;
   logic        bmem_rvalid;
`ifdef DMEM_PERF_CNT_EN
   logic [31:0] hit_count, miss_count;
`endif

   dmem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .dmem_addr   (dmem_addr),
      .dmem_rmask  (dmem_rmask),
      .dmem_wmask  (dmem_wmask),
      .dmem_wdata  (dmem_wdata),
      .dmem_rdata  (dmem_rdata),
      .dmem_resp   (dmem_resp),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid)
`ifdef DMEM_PERF_CNT_EN
      ,
      .hit_count   (hit_count),
      .miss_count  (miss_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] line_beat(input logic [31:0] a, input logic [1:0] i);
      if (a == 32'h0000_1000 && i == 2'd0) return 64'hBBBB_BBBB_AAAA_AAAA;
      return {a[15:0], 8'hA0 + {6'b0, i}, 8'h11, a[15:0], 8'hB0 + {6'b0, i}, 8'h22};
   endfunction

   // Burst-memory model: logs handshakes at negedge, drives ready/beats just after posedge.
   int          n_reads = 0, n_writes = 0, n_resps = 0, fill_cnt = 0;
   logic [31:0] last_read_addr = '0, fill_line = '0;
   logic [31:0] wr_addr_log [8];
   logic [63:0] wr_data_log [8];
   logic        toggle_ready = 1'b0;

   initial begin
      bmem_ready  = 1'b1;
      bmem_rvalid = 1'b0;
      bmem_rdata  = '0;
      bmem_raddr  = '0;
      forever begin
         @(negedge clk);
         if (bmem_read && bmem_ready) begin
            n_reads++;
            last_read_addr = bmem_addr;
            fill_line      = bmem_addr;
            fill_cnt       = 4;
         end
         if (bmem_write && bmem_ready) begin
            if (n_writes < 8) begin
               wr_addr_log[n_writes] = bmem_addr;
               wr_data_log[n_writes] = bmem_wdata;
            end
            n_writes++;
         end
         if (dmem_resp) n_resps++;
         @(posedge clk);
         #1;
         bmem_ready = toggle_ready ? ~bmem_ready : 1'b1;
         if (fill_cnt > 0) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = line_beat(fill_line, 2'(4 - fill_cnt));
            bmem_raddr  = fill_line;
            fill_cnt--;
         end else begin
            bmem_rvalid = 1'b0;
         end
      end
   end

   // Called just after a posedge; returns the word and the negedge count until dmem_resp.
   task automatic access(input string tag, input logic [31:0] a, input logic [3:0] rm,
                         input logic [3:0] wm, input logic [31:0] wd,
                         output logic [31:0] rd, output int cyc);
      dmem_addr  = a;
      dmem_rmask = rm;
      dmem_wmask = wm;
      dmem_wdata = wd;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!dmem_resp && cyc < 300);
      check({tag, "_resp"}, 64'(dmem_resp), 64'd1);
      rd = dmem_rdata;
      @(posedge clk);
      #1;
      dmem_rmask = 4'h0;
      dmem_wmask = 4'h0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] rd;
   int          cyc, r0, w0, p0;

   initial begin
      rst        = 1'b0;
      dmem_addr  = '0;
      dmem_rmask = 4'h0;
      dmem_wmask = 4'h0;
      dmem_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_resp",  64'(dmem_resp),  64'd0);
      check("rst_read",  64'(bmem_read),  64'd0);
      check("rst_write", 64'(bmem_write), 64'd0);
      check("rst_rdata", 64'(dmem_rdata), 64'd0);
      check("rst_baddr", 64'(bmem_addr),  64'd0);
      check("rst_bwdat", bmem_wdata,      64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Clean miss on 0x1004
      r0 = n_reads; w0 = n_writes; p0 = n_resps;
      access("miss1", 32'h0000_1004, 4'hF, 4'h0, 32'h0, rd, cyc);
      check("miss1_rdata", 64'(rd), 64'hBBBB_BBBB);
      check("miss1_lat",   64'(cyc), 64'd8);
      check("miss1_reads", 64'(n_reads - r0), 64'd1);
      check("miss1_raddr", 64'(last_read_addr), 64'h0000_1000);
      repeat (2) @(negedge clk);
      check("miss1_once",  64'(n_resps - p0), 64'd1);
      @(posedge clk); #1;

      // Back-to-back hits
      r0 = n_reads; w0 = n_writes; p0 = n_resps;
      access("hit0", 32'h0000_1000, 4'hF, 4'h0, 32'h0, rd, cyc);
      check("hit0_rdata", 64'(rd), 64'hAAAA_AAAA);
      check("hit0_lat",   64'(cyc), 64'd2);
      access("hit7", 32'h0000_101C, 4'hF, 4'h0, 32'h0, rd, cyc);
      check("hit7_rdata", 64'(rd), 64'h1000_A311);
      check("hit7_lat",   64'(cyc), 64'd2);
      check("hit_nobmem", 64'(n_reads - r0 + n_writes - w0), 64'd0);
      check("hit_resps",  64'(n_resps - p0), 64'd2);

      // Byte store then reload
      access("st", 32'h0000_1008, 4'h0, 4'b0100, 32'h00AB_0000, rd, cyc);
      check("st_rdata", 64'(rd), 64'h10AB_B122);
      check("st_lat",   64'(cyc), 64'd2);
      access("ld_st", 32'h0000_1008, 4'hF, 4'h0, 32'h0, rd, cyc);
      check("ld_st_rdata", 64'(rd), 64'h10AB_B122);

      // Dirty eviction with ready toggling
      toggle_ready = 1'b1;
      r0 = n_reads; w0 = n_writes;
      access("evict", 32'h0000_2000, 4'hF, 4'h0, 32'h0, rd, cyc);
      toggle_ready = 1'b0;
      check("evict_rdata",  64'(rd), 64'h2000_B022);
      check("evict_nwr",    64'(n_writes - w0), 64'd4);
      check("evict_reads",  64'(n_reads - r0), 64'd1);
      check("evict_raddr",  64'(last_read_addr), 64'h0000_2000);
      check("evict_waddr0", 64'(wr_addr_log[0]), 64'h0000_1000);
      check("evict_waddr3", 64'(wr_addr_log[3]), 64'h0000_1000);
      check("evict_wd0", wr_data_log[0], 64'hBBBB_BBBB_AAAA_AAAA);
      check("evict_wd1", wr_data_log[1], 64'h1000_A111_10AB_B122);
      check("evict_wd2", wr_data_log[2], 64'h1000_A211_1000_B222);
      check("evict_wd3", wr_data_log[3], 64'h1000_A311_1000_B322);
      check("evict_lat_min", 64'(cyc >= 14), 64'd1);

      // Reset during fill beat 2
      r0 = n_reads; p0 = n_resps;
      dmem_addr  = 32'h0000_3000;
      dmem_rmask = 4'hF;
      for (int i = 0; i < 20 && n_reads == r0; i++) @(negedge clk);
      check("rstfill_req", 64'(n_reads - r0), 64'd1);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rstfill_resp",  64'(dmem_resp),  64'd0);
      check("rstfill_read",  64'(bmem_read),  64'd0);
      check("rstfill_write", 64'(bmem_write), 64'd0);
      dmem_rmask = 4'h0;
      repeat (4) @(negedge clk);
      check("rstfill_noresp", 64'(n_resps - p0), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      r0 = n_reads;
      access("refill", 32'h0000_3004, 4'hF, 4'h0, 32'h0, rd, cyc);
      check("refill_rdata", 64'(rd), 64'h3000_A011);
      check("refill_reads", 64'(n_reads - r0), 64'd1);
      check("refill_lat",   64'(cyc), 64'd8);

`ifdef DMEM_PERF_CNT_EN
      do_reset();
      check("perf_rst_hit", 64'(hit_count), 64'd0);
      access("perf_m",  32'h0000_4000, 4'hF, 4'h0, 32'h0, rd, cyc);
      access("perf_h0", 32'h0000_4000, 4'hF, 4'h0, 32'h0, rd, cyc);
      access("perf_h1", 32'h0000_4004, 4'hF, 4'h0, 32'h0, rd, cyc);
      access("perf_h2", 32'h0000_4008, 4'hF, 4'h0, 32'h0, rd, cyc);
      @(negedge clk);
      check("perf_miss", 64'(miss_count), 64'd1);
      check("perf_hit",  64'(hit_count),  64'd3);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
